// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared defaults, legal-select limit and FSM state encoding
//                for the ALU sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int SEL_W_DEF  = 3;

    // Highest legal ALU select; anything above is flagged as an error.
    localparam logic [2:0] SEL_MAX = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Three-state sequencer feeding an external ALU with registered
//                operands, capturing its result and holding it for a
//                ready/valid consumer. Optional result counter enabled by
//                defining ALU_SEQ_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic [7:0]        stat_cnt
);

    state_e             state_q;
    logic               cmd_ready_q;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [SEL_W-1:0]   alu_sel_q;
    logic               res_valid_q;
    logic [DATA_W-1:0]  res_data_q;
    logic               res_err_q;
    logic [DATA_W-1:0]  acc_q;

    logic [DATA_W-1:0]  op_a_d;
    logic [DATA_W-1:0]  res_data_d;
    logic               res_err_d;
    logic               accept;
    logic               res_hs;

    always_comb begin
        op_a_d     = cmd_use_acc ? acc_q : cmd_a;
        res_err_d  = (alu_sel_q > SEL_W'(SEL_MAX));
        res_data_d = res_err_d ? '0 : alu_out;
    end

    // res_valid_q is only ever set in RESP, so res_ready elsewhere is inert.
    assign accept = cmd_valid && cmd_ready_q;
    assign res_hs = res_valid_q && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        alu_a_q     <= op_a_d;
                        alu_b_q     <= cmd_b;
                        alu_sel_q   <= cmd_sel;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= res_data_d;
                    res_err_q   <= res_err_d;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (res_hs) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        if (!res_err_q) begin
                            acc_q <= res_data_q;
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b0;
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

`ifdef ALU_SEQ_STATS_EN
    logic [7:0] stat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_q <= 8'h00;
        end else if (res_hs && (stat_cnt_q != 8'hFF)) begin
            stat_cnt_q <= stat_cnt_q + 8'd1;
        end
    end

    assign stat_cnt = stat_cnt_q;
`else
    assign stat_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Directed plus randomized bench for alu_seq_ctrl with an adder
//                ALU stub and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_use_acc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_err;
    logic [7:0] stat_cnt;

    int tests = 0;
    int fails = 0;
    int acc_m = 0;
    int cnt_m = 0;

`ifdef ALU_SEQ_STATS_EN
    localparam int STAT_FINAL = 255;
`else
    localparam int STAT_FINAL = 0;
`endif

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_sel     (cmd_sel),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .stat_cnt    (stat_cnt)
    );

    assign alu_out = alu_a + alu_b;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int stat_exp();
`ifdef ALU_SEQ_STATS_EN
        return cnt_m;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command: offer, check operands, check result, optional stall, handshake.
    task automatic run_cmd(input int a, input int b, input int sel, input int use_acc, input int hold);
        int waitc;
        int ea;
        int er;
        int ee;
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready !== 1'b1) return;

        ea = (use_acc != 0) ? acc_m : a;
        er = (sel <= 4) ? ((ea + b) % 16) : 0;
        ee = (sel > 4) ? 1 : 0;

        cmd_a       = 4'(a);
        cmd_b       = 4'(b);
        cmd_sel     = 3'(sel);
        cmd_use_acc = (use_acc != 0);
        cmd_valid   = 1'b1;
        res_ready   = 1'($urandom_range(0, 1));
        @(negedge clk);

        cmd_valid   = 1'($urandom_range(0, 1));
        cmd_a       = 4'($urandom_range(0, 15));
        cmd_b       = 4'($urandom_range(0, 15));
        cmd_use_acc = 1'($urandom_range(0, 1));
        res_ready   = 1'($urandom_range(0, 1));
        chk("exec_alu_a", 32'(alu_a), ea);
        chk("exec_alu_b", 32'(alu_b), b);
        chk("exec_alu_sel", 32'(alu_sel), sel);
        chk("exec_res_valid", {31'd0, res_valid}, 32'd0);
        chk("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);

        res_ready = 1'b0;
        chk("resp_res_valid", {31'd0, res_valid}, 32'd1);
        chk("resp_res_data", 32'(res_data), er);
        chk("resp_res_err", {31'd0, res_err}, ee);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_res_data", 32'(res_data), er);
            chk("hold_res_err", {31'd0, res_err}, ee);
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold_alu_a", 32'(alu_a), ea);
        end

        res_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        if (ee == 0) acc_m = er;
        if (cnt_m < 255) cnt_m++;
        chk("done_res_valid", {31'd0, res_valid}, 32'd0);
        chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("done_stat_cnt", 32'(stat_cnt), stat_exp());
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = 4'd0;
        cmd_b       = 4'd0;
        cmd_sel     = 3'd0;
        cmd_use_acc = 1'b0;
        res_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_err", {31'd0, res_err}, 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_stat_cnt", 32'(stat_cnt), 32'd0);
        rst_n = 1'b1;

        // Directed: add, accumulate, illegal select, acc preserved, long stall.
        run_cmd(5, 3, 0, 0, 0);
        run_cmd(0, 1, 1, 1, 0);
        run_cmd(7, 2, 5, 0, 1);
        run_cmd(0, 0, 0, 1, 0);
        run_cmd(3, 4, 7, 1, 5);
        run_cmd(15, 1, 4, 0, 0);

        for (int n = 0; n < 20; n++) begin
            run_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 2));
        end

        // Reset pulse while a command is in EXEC.
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd_a       = 4'd6;
        cmd_b       = 4'd6;
        cmd_sel     = 3'd0;
        cmd_use_acc = 1'b0;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_alu_a", 32'(alu_a), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        chk("mid_rst_stat_cnt", 32'(stat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = 0;
        cnt_m = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
        end
        run_cmd(9, 2, 0, 1, 0);

        // Long legal run to exercise counter saturation.
        for (int n = 0; n < 260; n++) begin
            run_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 4),
                    $urandom_range(0, 1), $urandom_range(0, 2));
        end
        chk("stat_final", 32'(stat_cnt), STAT_FINAL);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, 4, operand/result width.
REQ-003 Parameter SEL_W, 3, operation select width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command can be accepted.
REQ-008 cmd_a  in  DATA_W  operand A.
REQ-009 cmd_b  in  DATA_W  operand B.
REQ-010 cmd_sel  in  SEL_W  ALU operation select.
REQ-011 cmd_use_acc  in  1  when 1, the accumulator replaces cmd_a as operand A.
REQ-012 alu_a, alu_b  out  DATA_W  registered operands to the downstream ALU.
REQ-013 alu_sel  out  SEL_W  registered select to the ALU.
REQ-014 alu_out  in  DATA_W  combinational ALU result.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts the result.
REQ-017 res_data  out  DATA_W  captured result.
REQ-018 res_err  out  1  illegal select flag for the current result.
REQ-019 stat_cnt  out  8  completed-result count (see Configuration).

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-022 On accept, the block SHALL register alu_a (acc if cmd_use_acc, else cmd_a), alu_b and alu_sel, then go to EXEC.
REQ-023 On the edge leaving EXEC, the block SHALL capture alu_out into res_data, go to RESP and set res_valid; latency is 2 edges from accept to res_valid.
REQ-024 Legal selects SHALL be 000..100; for 101..111, res_data SHALL be 0 and res_err 1; otherwise res_err SHALL be 0.
REQ-025 res_valid, res_data and res_err SHALL stay stable in RESP until res_ready is 1.
REQ-026 On the edge where res_valid and res_ready are both 1, the block SHALL return to IDLE; when res_err is 0, it SHALL load res_data into acc.
REQ-027 alu_a, alu_b and alu_sel SHALL hold their last values outside EXEC.
REQ-028 Throughput SHALL be at most one command per 3 cycles; no command is accepted in EXEC or RESP.
REQ-029 res_ready asserted outside RESP SHALL be ignored.

Reset
REQ-030 While rst_n is 0, state SHALL be IDLE and all registered outputs, acc and stat_cnt SHALL be 0.
REQ-031 Reset in EXEC or RESP SHALL drop the in-flight command with no result delivered.

Configuration
REQ-032 With ALU_SEQ_STATS_EN defined, stat_cnt SHALL increment on each result handshake and saturate at 255.
REQ-033 Without ALU_SEQ_STATS_EN, stat_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-034 Package alu_seq_pkg SHALL hold DATA_W/SEL_W defaults, SEL_MAX = 3'b100 and the state enum.
REQ-035 No sub-module SHALL be used; the ALU is instantiated outside, next to this block.

Verification (bench ALU stub: alu_out = alu_a + alu_b mod 16)
REQ-036 Accept a=0101, b=0011, sel=000 -> res_valid 2 edges later, res_data=1000, res_err=0; stat_cnt=1 when the macro is on.
REQ-037 Next cmd_use_acc=1, b=0001, sel=001 -> alu_a=1000, res_data=1001.
REQ-038 sel=101 -> res_data=0000, res_err=1, acc unchanged.
REQ-039 Hold res_ready=0 for 5 cycles in RESP -> outputs stable, cmd_ready=0, cmd_valid ignored.
REQ-040 rst_n=0 pulse in EXEC -> immediate IDLE, outputs 0, no res_valid afterwards.
REQ-041 Run 260 legal commands with the macro on -> stat_cnt=255; with the macro off -> stat_cnt=0.
